// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO drain stage: occupancy encoding and default sizes.
// Slot count follows FIFO_STREAM_SKID_EN (two slots when defined, one otherwise).
package fifo_stream_pkg;

  typedef enum logic [1:0] {
    OCC_ZERO = 2'd0,
    OCC_ONE  = 2'd1,
    OCC_TWO  = 2'd2
  } occ_t;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 16;

`ifdef FIFO_STREAM_SKID_EN
  localparam int NUM_SLOTS = 2;
`else
  localparam int NUM_SLOTS = 1;
`endif

endpackage

// File: rtl/fifo_stream_if.sv
// FIFO-side pop handshake plus downstream valid/ready stream, bundled for the drain stage.
interface fifo_stream_if
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  // master: the drain stage itself; slave: the FIFO and downstream consumer
  modport master (
    input  fifo_empty, fifo_data, out_ready,
    output fifo_pop, out_valid, out_data
  );

  modport slave (
    output fifo_empty, fifo_data, out_ready,
    input  fifo_pop, out_valid, out_data
  );
endinterface

// File: rtl/fifo_stream_slot.sv
// One buffered data word: load-enabled register, asynchronously cleared to zero.
module fifo_stream_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;
endmodule

// File: rtl/fifo_stream_out.sv
// Drain stage: pops the show-ahead FIFO head into registered output slot(s) and counts transfers.
// FIFO_STREAM_SKID_EN adds a skid slot so fifo_pop no longer depends on out_ready.
module fifo_stream_out
  import fifo_stream_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  fifo_stream_if.master    bus,
  output logic [CNT_W-1:0] xfer_cnt
);
  occ_t             state_reg, state_next;
  logic             valid_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             room, pop, xfer;

  logic [NUM_SLOTS-1:0] slot_load;
  logic [WIDTH-1:0]     slot_d [NUM_SLOTS];
  logic [WIDTH-1:0]     slot_q [NUM_SLOTS];

  assign xfer = valid_reg && bus.out_ready;

`ifdef FIFO_STREAM_SKID_EN
  assign room = (state_reg != OCC_TWO);
`else
  assign room = (state_reg == OCC_ZERO) || bus.out_ready;
`endif

  // rst_n gating keeps the FIFO untouched while the stage is held in reset
  assign pop = rst_n && !bus.fifo_empty && !flush && room;

  always_comb begin
    state_next = state_reg;
    slot_load  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      slot_d[i] = bus.fifo_data;
    end

    case (state_reg)
      OCC_ZERO: begin
        if (pop) begin
          state_next   = OCC_ONE;
          slot_load[0] = 1'b1;
        end
      end
      OCC_ONE: begin
`ifdef FIFO_STREAM_SKID_EN
        if (xfer && pop) begin
          slot_load[0] = 1'b1;
        end else if (xfer) begin
          state_next = OCC_ZERO;
        end else if (pop) begin
          state_next   = OCC_TWO;
          slot_load[1] = 1'b1;
        end
`else
        // a pop here implies out_ready, hence a transfer: replace in place
        if (pop) begin
          slot_load[0] = 1'b1;
        end else if (xfer) begin
          state_next = OCC_ZERO;
        end
`endif
      end
      OCC_TWO: begin
`ifdef FIFO_STREAM_SKID_EN
        if (xfer) begin
          state_next   = OCC_ONE;
          slot_load[0] = 1'b1;
          slot_d[0]    = slot_q[1];
        end
`else
        state_next = OCC_ZERO;
`endif
      end
      default: state_next = OCC_ZERO;
    endcase

    if (flush) begin
      state_next = OCC_ZERO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= OCC_ZERO;
      valid_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      valid_reg <= (state_next != OCC_ZERO);
      if (xfer) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    fifo_stream_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (slot_load[gi]),
      .d     (slot_d[gi]),
      .q     (slot_q[gi])
    );
  end

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = valid_reg;
  assign bus.out_data  = slot_q[0];
  assign xfer_cnt      = cnt_reg;
endmodule
